sdram_arbit: RTL

- Top-level command arbiter for the 100 MHz SDRAM controller.
- Sequences the init, auto-refresh, write and read sub-modules, and grants exactly one of them ownership of the SDRAM command/address/data pins.
- Muxes the owner's command, address and bank onto the device pins, and drives the DQ output enable during writes.
- Enforces priority refresh > write > read, with a watchdog against a hung owner.

---
 rtl/sdram_arbit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit - command arbiter for the 100 MHz SDRAM controller.
//
// Sequences the init, auto-refresh, write and read sub-modules and hands one of
// them at a time the SDRAM command/address/bank pins. Priority is
// refresh > write > read. Once granted, an owner keeps the bus until it pulses
// its end flag; nothing pre-empts it. A watchdog returns the bus to
// arbitration if an owner holds it for TIMEOUT_CYC cycles.
//
// Optional build macro:
//   ARB_RR_EN - alternate write/read priority when both are requesting.
//               Refresh always stays highest.
//
// Ports:
//   sclk, s_rst                  clock, synchronous active-high reset
//   flag_init_end                init done (level)
//   init_cmd/init_addr           init module command / address
//   ref_req/flag_ref_end         refresh request (level) / done (pulse)
//   ref_cmd/ref_addr, ref_en     refresh command / address, grant pulse
//   wr_req/flag_wr_end           write request (level) / done (pulse)
//   wr_cmd/wr_addr/wr_bank       write command / address / bank
//   wr_data, wr_en               write data, grant pulse
//   rd_req/flag_rd_end           read request (level) / done (pulse)
//   rd_cmd/rd_addr/rd_bank       read command / address / bank
//   rd_en                        read grant pulse
//   sdram_cke, sdram_*_n         clock enable, command pins
//   sdram_bank, sdram_addr       bank and address pins
//   sdram_dq_out, sdram_dq_oe    DQ drive value and output enable
//   err_timeout                  watchdog fired (pulse)
// -----------------------------------------------------------------------------
// state   | meaning
// --------+---------------------------------------------------------
// S_INIT  | init module owns the pins, waiting for flag_init_end
// S_ARBIT | bus idle, NOP on pins, choosing the next owner
// S_AREF  | refresh module owns the pins
// S_WRITE | write module owns the pins, DQ driven
// S_READ  | read module owns the pins
// -----------------------------------------------------------------------------
module sdram_arbit #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int TO_W        = 10
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        flag_init_end,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        ref_req,
    input  logic        flag_ref_end,
    input  logic [3:0]  ref_cmd,
    input  logic [12:0] ref_addr,
    output logic        ref_en,
    input  logic        wr_req,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic [15:0] wr_data,
    output logic        wr_en,
    input  logic        rd_req,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_bank,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        err_timeout
);

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

    localparam logic [3:0]      CMD_NOP = 4'b0111;
    // The grant cycle counts as the first held cycle, so the last permitted
    // cycle is the one where the counter shows TIMEOUT_CYC-1.
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            ref_en_q, ref_en_d;
    logic            wr_en_q, wr_en_d;
    logic            rd_en_q, rd_en_d;
    logic            err_q, err_d;
    logic            cke_q;
    logic            wd_expired;
    logic            owner_d;
    logic            rd_first;

`ifdef ARB_RR_EN
    logic last_wr_q, last_wr_d;
    assign rd_first = rd_req && last_wr_q;
`else
    assign rd_first = 1'b0;
`endif

    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  if (flag_init_end) state_d = S_ARBIT;
            S_ARBIT: begin
                if (ref_req)                   state_d = S_AREF;
                else if (wr_req && !rd_first)  state_d = S_WRITE;
                else if (rd_req)               state_d = S_READ;
            end
            S_AREF:  if (flag_ref_end || wd_expired) state_d = S_ARBIT;
            S_WRITE: if (flag_wr_end  || wd_expired) state_d = S_ARBIT;
            S_READ:  if (flag_rd_end  || wd_expired) state_d = S_ARBIT;
            default: state_d = S_INIT;
        endcase

        owner_d = (state_d == S_AREF) || (state_d == S_WRITE) || (state_d == S_READ);
        wd_d    = (owner_d && (state_d == state_q)) ? wd_q + 1'b1 : '0;
        // Registered so the pulse lands on the stuck owner's final cycle.
        err_d   = owner_d && (wd_d == WD_LAST);

        ref_en_d = (state_q == S_ARBIT) && (state_d == S_AREF);
        wr_en_d  = (state_q == S_ARBIT) && (state_d == S_WRITE);
        rd_en_d  = (state_q == S_ARBIT) && (state_d == S_READ);

`ifdef ARB_RR_EN
        last_wr_d = last_wr_q;
        if (wr_en_d)      last_wr_d = 1'b1;
        else if (rd_en_d) last_wr_d = 1'b0;
`endif
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q  <= S_INIT;
            wd_q     <= '0;
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            err_q    <= 1'b0;
            cke_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_wr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            ref_en_q <= ref_en_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            err_q    <= err_d;
            cke_q    <= 1'b1;
`ifdef ARB_RR_EN
            last_wr_q <= last_wr_d;
`endif
        end
    end

    // Pin mux keyed only by the registered state, never by request inputs.
    logic [3:0]  cmd_mux;
    logic [12:0] addr_mux;
    logic [1:0]  bank_mux;

    always_comb begin
        cmd_mux  = CMD_NOP;
        addr_mux = '0;
        bank_mux = '0;
        unique case (state_q)
            S_INIT:  begin cmd_mux = init_cmd; addr_mux = init_addr; end
            S_AREF:  begin cmd_mux = ref_cmd;  addr_mux = ref_addr;  end
            S_WRITE: begin cmd_mux = wr_cmd;   addr_mux = wr_addr; bank_mux = wr_bank; end
            S_READ:  begin cmd_mux = rd_cmd;   addr_mux = rd_addr; bank_mux = rd_bank; end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
    assign sdram_addr   = addr_mux;
    assign sdram_bank   = bank_mux;
    assign sdram_dq_out = wr_data;
    assign sdram_dq_oe  = (state_q == S_WRITE);
    assign sdram_cke    = cke_q;
    assign ref_en       = ref_en_q;
    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;
    assign err_timeout  = err_q;

endmodule
